// File: rtl/array_ops_pkg.sv
`default_nettype none
// ============================================================================
// Module      : array_ops_pkg
// Description : Shared width helpers and default geometry for the array
//               packing/flattening blocks.
//               clog2_cnt(n)      : width needed to hold a count 0..n
//               flat_width(bw, n) : width of a flat word of n bw-bit elements
// Revision    : 1.0 - initial release
// ============================================================================
package array_ops_pkg;

  localparam int c_default_bit_width = 4;
  localparam int c_default_cols      = 8;

  // A count runs 0..n inclusive, hence n+1 distinct values.
  function automatic int clog2_cnt(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int flat_width(input int bit_width, input int cols);
    return bit_width * cols;
  endfunction

endpackage : array_ops_pkg
`default_nettype wire

// File: rtl/convert_2d_to_1d_array.sv
`default_nettype none
// ============================================================================
// Module      : convert_2d_to_1d_array
// Description : Pure combinational flattening of an unpacked array of
//               BIT_WIDTH-bit elements into one packed word, element 0 at
//               the LSBs.
//   in_array : input  [BIT_WIDTH-1:0] x COLS   source elements
//   out_flat : output [COLS*BIT_WIDTH-1:0]     flattened word
// Revision    : 1.0 - initial release
// ============================================================================
module convert_2d_to_1d_array
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = c_default_bit_width,
  parameter int COLS      = c_default_cols
) (
  input  logic [BIT_WIDTH-1:0]                     in_array [COLS],
  output logic [flat_width(BIT_WIDTH, COLS)-1:0]   out_flat
);

  for (genvar k = 0; k < COLS; k++) begin : g_col
    assign out_flat[k*BIT_WIDTH +: BIT_WIDTH] = in_array[k];
  end

endmodule : convert_2d_to_1d_array
`default_nettype wire

// File: rtl/array_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : array_row_packer
// Description : Streaming packer collecting BIT_WIDTH-bit elements into a
//               COLS-wide flat word (column 0 at LSBs). in_last closes a
//               word early; unused upper columns are zero.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : element            in_valid / in_ready : input handshake
//   in_last    : element closes the current word
//   out_data   : packed word        out_valid / out_ready : output handshake
//   out_count  : number of valid columns in out_data (1..COLS)
// Revision    : 1.0 - initial release
// ============================================================================
module array_row_packer
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = c_default_bit_width,
  parameter int COLS      = c_default_cols
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BIT_WIDTH-1:0]                   in_data,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic [flat_width(BIT_WIDTH, COLS)-1:0] out_data,
  output logic [clog2_cnt(COLS)-1:0]             out_count,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int IDX_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W  = clog2_cnt(COLS);
  localparam int WORD_W = flat_width(BIT_WIDTH, COLS);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(COLS - 1);

  logic [BIT_WIDTH-1:0] r_cols [COLS];
  logic [IDX_W-1:0]     r_idx;
  logic [WORD_W-1:0]    r_out_data;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_valid;

  logic [BIT_WIDTH-1:0] w_masked [COLS];
  logic [WORD_W-1:0]    w_next_word;
  logic                 w_accept;
  logic                 w_complete;

  // The FILL/HOLD distinction is carried entirely by r_out_valid: the
  // input side may advance whenever the output register is empty or is
  // being drained in this same cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && ((r_idx == c_last_idx) || in_last);

  // Next-word view of the buffer: stored columns below idx, the incoming
  // element at idx, zero above, so a completing element can be packed in
  // the same cycle it is accepted.
  always_comb begin
    for (int k = 0; k < COLS; k++) begin
      w_masked[k] = '0;
      if (IDX_W'(k) < r_idx) begin
        w_masked[k] = r_cols[k];
      end else if (IDX_W'(k) == r_idx) begin
        w_masked[k] = in_data;
      end
    end
  end

  convert_2d_to_1d_array #(
    .BIT_WIDTH (BIT_WIDTH),
    .COLS      (COLS)
  ) u_flatten (
    .in_array (w_masked),
    .out_flat (w_next_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < COLS; k++) begin
        r_cols[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_idx <= '0;
          for (int k = 0; k < COLS; k++) begin
            r_cols[k] <= '0;
          end
        end else begin
          r_cols[r_idx] <= in_data;
          r_idx         <= r_idx + IDX_W'(1);
        end
      end

      // A completing word overrides a simultaneous drain so consecutive
      // words can leave with no bubble.
      if (w_complete) begin
        r_out_data  <= w_next_word;
        r_out_count <= CNT_W'(r_idx) + CNT_W'(1);
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_valid = r_out_valid;

endmodule : array_row_packer
`default_nettype wire

// File: tb/tb_array_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_array_row_packer
// Description : Self-checking bench for array_row_packer (BIT_WIDTH=4,
//               COLS=8 main instance plus a COLS=1 instance). A queue-based
//               reference model tracks accepted elements and the expected
//               output word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_array_row_packer;

  localparam int NC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  logic [3:0]  c1_in_data;
  logic        c1_in_valid;
  logic        c1_in_last;
  logic        c1_in_ready;
  logic [3:0]  c1_out_data;
  logic [0:0]  c1_out_count;
  logic        c1_out_valid;
  logic        c1_out_ready;

  always #5 clk = ~clk;

  array_row_packer #(.BIT_WIDTH(4), .COLS(NC)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );

  array_row_packer #(.BIT_WIDTH(4), .COLS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(c1_in_data), .in_valid(c1_in_valid), .in_last(c1_in_last), .in_ready(c1_in_ready),
    .out_data(c1_out_data), .out_count(c1_out_count), .out_valid(c1_out_valid),
    .out_ready(c1_out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the elements of the word in progress, and the word
  // currently presented on the output.
  int          m_elems[$];
  logic        m_valid;
  logic [31:0] m_data;
  int          m_count;

  task automatic model_reset();
    m_elems.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_count = 0;
  endtask

  function automatic logic model_ready();
    return !m_valid || out_ready;
  endfunction

  task automatic drive(input logic v, input logic [3:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  // Advance one clock and update the model from the inputs that were
  // present at that edge; leaves time at edge+1 for sampling.
  task automatic tick();
    logic acc, drained;
    logic [31:0] w;
    @(posedge clk);
    acc     = in_valid && model_ready();
    drained = m_valid && out_ready;
    if (acc) begin
      m_elems.push_back(int'(in_data));
      if (in_last || m_elems.size() == NC) begin
        w = '0;
        foreach (m_elems[i]) w = w | (32'(m_elems[i]) << (4 * i));
        m_data  = w;
        m_count = m_elems.size();
        m_valid = 1'b1;
        m_elems.delete();
      end else if (drained) begin
        m_valid = 1'b0;
      end
    end else if (drained) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1);
      tick();
      checks++;
      if (out_valid !== (i == 7)) begin
        errors++; $display("FAIL full_valid elem=%0d got %b exp %b", i, out_valid, (i == 7));
      end
    end
    checks++; if (out_data !== 32'h76543210) begin errors++; $display("FAIL full_data got %h exp 76543210", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", out_count); end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_one_cycle got %b exp 0", out_valid); end
  endtask

  task automatic test_partial();
    logic [3:0] abc [3];
    abc[0] = 4'hA; abc[1] = 4'hB; abc[2] = 4'hC;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, abc[i], (i == 2), 1'b1);
      tick();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL partial_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h00000CBA) begin errors++; $display("FAIL partial_data got %h exp 00000cba", out_data); end
    checks++; if (out_count !== 4'd3) begin errors++; $display("FAIL partial_count got %0d exp 3", out_count); end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1);
      tick();
      checks++;
      if (out_valid !== (i == 8)) begin
        errors++; $display("FAIL partial_next_valid elem=%0d got %b exp %b", i, out_valid, (i == 8));
      end
    end
    checks++; if (out_data !== 32'h87654321) begin errors++; $display("FAIL partial_next_data got %h exp 87654321", out_data); end
    checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL partial_next_count got %0d exp 8", out_count); end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i + 2), 1'b0, 1'b0);
      tick();
    end
    checks++; if (out_data !== 32'h98765432) begin errors++; $display("FAIL bp_data got %h exp 98765432", out_data); end
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got %b exp 0", c, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h98765432 || out_count !== 4'd8) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h n=%0d exp v=1 d=98765432 n=8",
                           c, out_valid, out_data, out_count);
      end
    end
    // Release: handshake and a single-element word in the same cycle.
    drive(1'b1, 4'h5, 1'b1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000005 || out_count !== 4'd1) begin
      errors++; $display("FAIL bp_col0 got v=%b d=%h n=%0d exp v=1 d=00000005 n=1", out_valid, out_data, out_count);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    int dut_words = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 4'($urandom), 1'b0, 1'b1);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready elem=%0d got %b exp 1", i, in_ready); end
      tick();
      if (out_valid === 1'b1) dut_words++;
      checks++;
      if (out_valid !== ((i % 8) == 7)) begin
        errors++; $display("FAIL b2b_valid elem=%0d got %b exp %b", i, out_valid, ((i % 8) == 7));
      end
      if ((i % 8) == 7) begin
        checks++;
        if (out_data !== m_data || out_count !== 4'd8) begin
          errors++; $display("FAIL b2b_word elem=%0d got d=%h n=%0d exp d=%h n=8", i, out_data, out_count, m_data);
        end
      end
    end
    checks++; if (dut_words != 3) begin errors++; $display("FAIL b2b_words got %0d exp 3", dut_words); end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 4'((i % 8) + 1), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 4'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got v=%b d=%h n=%0d rdy=%b exp v=0 d=0 n=0 rdy=1",
                         out_valid, out_data, out_count, in_ready);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(15 - i), 1'b0, 1'b1);
      tick();
      checks++;
      if (out_valid !== (i == 7)) begin
        errors++; $display("FAIL rst_stream_valid elem=%0d got %b exp %b", i, out_valid, (i == 7));
      end
    end
    checks++;
    if (out_data !== 32'h89ABCDEF || out_count !== 4'd8) begin
      errors++; $display("FAIL rst_stream_word got d=%h n=%0d exp d=89abcdef n=8", out_data, out_count);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %b exp %b", c, in_ready, model_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid cyc=%0d got %b exp %b", c, out_valid, m_valid);
      end else if (m_valid && (out_data !== m_data || out_count !== 4'(m_count))) begin
        errors++; $display("FAIL rand_word cyc=%0d got d=%h n=%0d exp d=%h n=%0d",
                           c, out_data, out_count, m_data, m_count);
      end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_cols1();
    logic [3:0] vals [2];
    vals[0] = 4'h3; vals[1] = 4'h5;
    c1_out_ready = 1'b1;
    c1_in_last   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c1_in_valid = 1'b1;
      c1_in_data  = vals[i];
      @(posedge clk); #1;
      checks++;
      if (c1_out_valid !== 1'b1 || c1_out_data !== vals[i] || c1_out_count !== 1'b1) begin
        errors++; $display("FAIL cols1_word%0d got v=%b d=%h n=%0d exp v=1 d=%h n=1",
                           i, c1_out_valid, c1_out_data, c1_out_count, vals[i]);
      end
    end
    c1_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (c1_out_valid !== 1'b0) begin errors++; $display("FAIL cols1_drain got %b exp 0", c1_out_valid); end
  endtask

  initial begin
    c1_in_data   = 4'h0;
    c1_in_valid  = 1'b0;
    c1_in_last   = 1'b0;
    c1_out_ready = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_cols1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_array_row_packer
`default_nettype wire

// File: doc/array_row_packer.md
# array_row_packer

Streaming packer that turns a sequence of BIT_WIDTH-bit elements into one flat COLS*BIT_WIDTH-bit word. Column 0 sits at the LSBs. It sits between an element-serial producer and any consumer of flat packed vectors. It sequences the existing 2D-to-1D flattening datapath with valid/ready handshakes on both sides. Early termination via `in_last` emits partial words zero-padded.

## Interface
Parameters:
- BIT_WIDTH, 4, width of one element
- COLS, 8, elements per packed word (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  BIT_WIDTH  element
- in_valid  input  1  element valid
- in_last  input  1  element closes current word (qualified by in_valid)
- in_ready  output  1  element accepted when in_valid && in_ready
- out_data  output  COLS*BIT_WIDTH  packed word, column k at bits [k*BIT_WIDTH +: BIT_WIDTH]
- out_count  output  $clog2(COLS+1)  number of valid columns in out_data (1..COLS)
- out_valid  output  1  word valid
- out_ready  input  1  word consumed when out_valid && out_ready

## Operation
- Column buffer `cols[COLS]`, write index `idx` (0..COLS-1), output register (data, count, valid).
- States:
  - FILL: out_valid=0, or the output is draining this cycle.
  - HOLD: out_valid=1 && !out_ready.
  - The state is derived from out_valid; no separate encoding is needed.
- in_ready = !out_valid || out_ready. This is a combinational path from out_ready. in_ready never depends on in_valid or in_last.
- On element accept:
  - cols[idx] <= in_data.
  - If idx==COLS-1 or in_last, the word completes:
    - Output register <= flattened cols with the new element included and columns > idx forced to 0.
    - out_count <= idx+1; out_valid <= 1.
    - idx <= 0; cols cleared to 0.
  - Otherwise idx <= idx+1.
- When out_valid && out_ready and no word completes that cycle, out_valid <= 0.
- Simultaneous drain and completion: the new word replaces the drained one and out_valid stays 1. This gives full throughput.
- in_last with idx==COLS-1 is equivalent to a normal full completion; out_count=COLS.
- COLS==1: every accepted element completes a word; idx is constantly 0.
- Reset (async, any time, including mid-fill or in HOLD):
  - idx=0, cols=0.
  - out_data=0, out_count=0, out_valid=0.
  - in_ready=1 after reset (out_valid=0).
  - A partial word in progress is discarded.

## Timing
- Latency: out_valid rises the cycle after the completing element's accept edge.
- Throughput: 1 element/cycle sustained while out_ready=1. No bubble between words.
- While HOLD:
  - out_data and out_count stay stable.
  - in_ready=0, so no element is accepted and idx/cols are frozen.
- out_count is 0 only while out_valid=0 after reset. After the first word it retains the last value; it is don't-care when out_valid=0.

## Structure
- Shared package `array_ops_pkg`:
  - function `clog2_cnt(n)` returning the out_count width.
  - Element/word width helper localparams reused by other array blocks.
- One sub-module, natural and required: instantiate `convert_2d_to_1d_array` (BIT_WIDTH, COLS) to flatten the masked column buffer into the next-word value. No hand-written bit slicing in the controller.
- Controller: idx counter, column buffer with zero-mask, output register. Estimated 150–250 lines.

## Test plan
All scenarios use BIT_WIDTH=4 and COLS=8.
- Full words: stream 0,1,…,7 with out_ready=1 → out_data=32'h76543210, out_count=8, out_valid high for exactly 1 cycle, one cycle after the 8th accept.
- Partial word: A,B,C with in_last on C → out_data=32'h00000CBA, out_count=3. The following 8 elements 1..8 → 32'h87654321, count 8 (no stale columns).
- Backpressure:
  - Complete a word with out_ready=0 → in_ready=0 and out_data stable for 5 cycles; extra in_valid elements are not accepted.
  - Raise out_ready → handshake occurs, in_ready=1 in the same cycle, and the next element lands in column 0.
- Back-to-back: 24 elements with continuous in_valid and out_ready=1 → 24 accepts in 24 cycles and 3 words, each valid in the cycle after its 8th element, with no gaps.
- Reset mid-operation:
  - Assert rst after 5 accepts → all outputs 0 immediately (asynchronous, before the next edge).
  - Deassert, then stream 8 elements F,E,…,8 → single word 32'h89ABCDEF, count 8.
- Degenerate parameter COLS=1: stream 3,5 → two words 4'h3 then 4'h5, each with out_count=1.
